// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// The FSM encoding and lane constants live here so the CPU core can use them too.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUS_IF  = 2'd1,
    ARB_BUS_MEM = 2'd2,
    ARB_DONE    = 2'd3
  } arb_state_e;

  localparam int         ARB_DEFAULT_TIMEOUT = 15;
  localparam logic [3:0] MEM_SEL_WORD        = 4'b1111;

  function automatic logic arb_state_bus(arb_state_e s);
    return (s == ARB_BUS_IF) || (s == ARB_BUS_MEM);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog: reloads to 1 on clear, counts while enabled, and flags
// expiry once the count reaches TIMEOUT. The count saturates at 255.
module mem_arb_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd1;
    end else if (enable && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory bus; data wins.
// Registered handshake with watchdog abort and a combinational pipeline stall.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_ready,
  input  logic              mem_readEnable,
  input  logic              mem_writeEnable,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_error,
  output logic              stall_req
);

  arb_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              bus_error_q, bus_error_d;

  logic              mem_pending;
  logic              tmr_clear;
  logic              tmr_expired;
  logic [DATA_W-1:0] result;

  assign mem_pending = mem_readEnable | mem_writeEnable;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (arb_state_bus(state_q)),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    if_inst_d   = '0;
    mem_rdata_d = '0;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    bus_error_d = 1'b0;
    tmr_clear   = 1'b0;
    result      = bus_ack ? bus_rdata : '0;

    case (state_q)
      ARB_IDLE: begin
        if (mem_pending) begin
          state_d     = ARB_BUS_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_writeEnable;
          bus_addr_d  = mem_addr;
          bus_sel_d   = mem_sel;
          bus_wdata_d = mem_wdata;
          tmr_clear   = 1'b1;
        end else if (if_req) begin
          state_d     = ARB_BUS_IF;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_sel_d   = MEM_SEL_WORD;
          bus_wdata_d = '0;
          tmr_clear   = 1'b1;
        end
      end

      ARB_BUS_IF, ARB_BUS_MEM: begin
        // An ack in the expiry cycle still completes the access normally.
        if (bus_ack || tmr_expired) begin
          state_d     = ARB_DONE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_error_d = ~bus_ack;
          if (state_q == ARB_BUS_MEM) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = bus_we_q ? '0 : result;
          end else begin
            if_ready_d = 1'b1;
            if_inst_d  = result;
          end
        end
      end

      ARB_DONE: state_d = ARB_IDLE;

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign bus_error = bus_error_q;

  assign stall_req = (if_req & ~if_ready_q) | (mem_pending & ~mem_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// scored against a transaction-level model of grant order, latency and timeout.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_inst;
  logic          if_ready;
  logic          mem_readEnable;
  logic          mem_writeEnable;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_sel;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_sel;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          bus_error;
  logic          stall_req;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_inst         (if_inst),
    .if_ready        (if_ready),
    .mem_readEnable  (mem_readEnable),
    .mem_writeEnable (mem_writeEnable),
    .mem_addr        (mem_addr),
    .mem_sel         (mem_sel),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready),
    .bus_req         (bus_req),
    .bus_we          (bus_we),
    .bus_addr        (bus_addr),
    .bus_sel         (bus_sel),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .bus_error       (bus_error),
    .stall_req       (stall_req)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Expected contents of the requests currently presented by the "CPU".
  logic [AW-1:0] i_addr;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_sel;
  logic [DW-1:0] m_wdata;
  logic          m_we;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic new_mem();
    logic [1:0] rw;
    rw      = 2'($urandom_range(1, 3));
    m_addr  = $urandom;
    m_sel   = 4'($urandom);
    m_wdata = $urandom;
    m_we    = rw[1];
    mem_readEnable  = rw[0];
    mem_writeEnable = rw[1];
    mem_addr  = m_addr;
    mem_sel   = m_sel;
    mem_wdata = m_wdata;
  endtask

  task automatic new_if();
    i_addr  = $urandom;
    if_addr = i_addr;
    if_req  = 1'b1;
  endtask

  // Entered at a falling edge with the DUT idle and the request(s) presented.
  // Returns at the falling edge of the idle cycle after the ready pulse.
  task automatic serve(input bit is_mem, input int ack_delay, input bit late_mem);
    logic [31:0] e_addr, e_wdata, ack_data, e_data;
    logic        e_we, e_err, other;
    logic [3:0]  e_sel;
    int          busy, e_busy;
    e_addr   = is_mem ? m_addr : i_addr;
    e_we     = is_mem ? m_we : 1'b0;
    e_sel    = is_mem ? m_sel : 4'b1111;
    e_wdata  = m_wdata;
    e_busy   = (ack_delay + 1 <= TO) ? ack_delay + 1 : TO;
    e_err    = (ack_delay + 1 > TO);
    ack_data = '0;
    busy     = 0;

    @(negedge clk);
    chk_eq("req_latency", bus_req, 1);
    while (bus_req === 1'b1 && busy < TO + 4) begin
      busy++;
      chk_eq("bus_addr", bus_addr, e_addr);
      chk_eq("bus_we", bus_we, e_we);
      chk_eq("bus_sel", bus_sel, e_sel);
      if (is_mem) chk_eq("bus_wdata", bus_wdata, e_wdata);
      chk_eq("stall_busy", stall_req, 1);
      bus_rdata = $urandom;
      bus_ack   = (busy == ack_delay + 1);
      if (bus_ack) ack_data = bus_rdata;
      if (is_mem) begin
        mem_addr  = $urandom;
        mem_sel   = 4'($urandom);
        mem_wdata = $urandom;
      end else begin
        if_addr = $urandom;
      end
      if (late_mem && busy == 1) new_mem();
      @(negedge clk);
    end
    chk_eq("busy_len", busy, e_busy);

    bus_ack = 1'($urandom_range(0, 1));
    e_data  = (e_err || (is_mem && m_we && !late_mem)) ? 32'h0 : ack_data;
    if (is_mem) begin
      chk_eq("mem_ready", mem_ready, 1);
      chk_eq("if_ready_quiet", if_ready, 0);
      chk_eq("mem_rdata", mem_rdata, e_data);
    end else begin
      chk_eq("if_ready", if_ready, 1);
      chk_eq("mem_ready_quiet", mem_ready, 0);
      chk_eq("if_inst", if_inst, e_data);
    end
    chk_eq("bus_error", bus_error, e_err);
    other = is_mem ? if_req : (mem_readEnable | mem_writeEnable);
    chk_eq("stall_done", stall_req, other);

    if (is_mem) begin
      mem_readEnable  = 1'b0;
      mem_writeEnable = 1'b0;
    end else begin
      if_req = 1'b0;
    end

    @(negedge clk);
    chk_eq("idle_bus_req", bus_req, 0);
    chk_eq("idle_ready", {30'd0, if_ready, mem_ready}, 0);
    chk_eq("idle_error", bus_error, 0);
    chk_eq("idle_stall", stall_req, if_req | mem_readEnable | mem_writeEnable);
    bus_ack = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int kind, d1, d2;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_readEnable = 1'b0; mem_writeEnable = 1'b0;
    mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    i_addr = '0; m_addr = '0; m_sel = '0; m_wdata = '0; m_we = 1'b0;

    #2;
    chk_eq("rst_bus", {bus_req, bus_we, bus_sel, bus_error}, 0);
    chk_eq("rst_addr", bus_addr, 0);
    chk_eq("rst_wdata", bus_wdata, 0);
    chk_eq("rst_inst", if_inst, 0);
    chk_eq("rst_rdata", mem_rdata, 0);
    chk_eq("rst_ready", {if_ready, mem_ready}, 0);
    chk_eq("rst_stall", stall_req, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // fetch only, ack in the first busy cycle
    i_addr = 32'h100; if_addr = i_addr; if_req = 1'b1;
    serve(0, 0, 0);

    // data read and fetch together: data first, fetch three cycles later
    new_if();
    m_addr = 32'h200; m_sel = 4'b1111; m_wdata = '0; m_we = 1'b0;
    mem_addr = m_addr; mem_sel = m_sel; mem_wdata = m_wdata;
    mem_readEnable = 1'b1;
    serve(1, 0, 0);
    serve(0, 0, 0);

    // write with ack on the third busy cycle
    m_addr = 32'h300; m_sel = 4'b0011; m_wdata = 32'hDEADBEEF; m_we = 1'b1;
    mem_addr = m_addr; mem_sel = m_sel; mem_wdata = m_wdata;
    mem_writeEnable = 1'b1;
    serve(1, 2, 0);

    // fetch with no ack at all: watchdog abort
    new_if();
    serve(0, 1000, 0);

    // reset in the middle of a data access, then re-issue
    new_mem();
    @(negedge clk);
    chk_eq("pre_rst_req", bus_req, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_eq("async_rst_req", bus_req, 0);
    chk_eq("async_rst_ready", mem_ready, 0);
    @(negedge clk);
    chk_eq("rst_no_ready", mem_ready, 0);
    rst = 1'b0;
    serve(1, 0, 0);

    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 3);
      d1   = $urandom_range(0, 5);
      d2   = $urandom_range(0, 5);
      case (kind)
        0: begin new_if(); serve(0, d1, 0); end
        1: begin new_mem(); serve(1, d1, 0); end
        2: begin new_if(); new_mem(); serve(1, d1, 0); serve(0, d2, 0); end
        default: begin new_if(); serve(0, d1, 1); serve(1, d2, 0); end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
